pic_inta_sequencer: RTL

- Control sequencer for the 8259-style interrupt controller, in 8086 mode.
- Owns the in-service register (ISR) and the priority rotation value. Both feed the priority resolver.
- Consumes the resolver's one-hot result, raises INT to the CPU, and runs the two-pulse INTA handshake.
- Drives the interrupt vector onto the data bus and executes OCW2 end-of-interrupt and rotation commands.

---
 rtl/pic_pkg.sv | 21 ++
 rtl/pic_inta_sequencer_edge.sv | 29 ++
 rtl/pic_inta_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// pic_pkg: shared types, OCW2 encodings and helpers for the 8259-style controller.
package pic_pkg;
    localparam int LVL_W = 3;

    typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

    localparam logic [2:0] OCW2_NS_EOI   = 3'b001;
    localparam logic [2:0] OCW2_S_EOI    = 3'b011;
    localparam logic [2:0] OCW2_ROT_NS   = 3'b101;
    localparam logic [2:0] OCW2_ROT_S    = 3'b111;
    localparam logic [2:0] OCW2_SET_PRI  = 3'b110;
    localparam logic [2:0] OCW2_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NOP      = 3'b010;

    function automatic logic [LVL_W-1:0] onehot_to_level(input logic [7:0] v);
        onehot_to_level = '0;
        for (int i = 0; i < 8; i++)
            if (v[i]) onehot_to_level = LVL_W'(i);
    endfunction
endpackage

// File: rtl/pic_inta_sequencer_edge.sv
// inta_edge_detect: optional two-flop synchronizer on inta_n plus fall/rise pulse generation.
module inta_edge_detect #(
    parameter bit SYNC_INTA = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic inta_n_i,
    output logic fall_o,
    output logic rise_o
);
    logic [1:0] sync_q;
    logic       prev_q;
    logic       cur;

    assign cur = SYNC_INTA ? sync_q[1] : inta_n_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], inta_n_i};
            prev_q <= cur;
        end
    end

    assign fall_o = prev_q & ~cur;
    assign rise_o = ~prev_q & cur;
endmodule

// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: owns ISR and priority rotation, raises INT, runs the 8086 two-pulse INTA
// handshake and executes OCW2 end-of-interrupt / rotation commands.
module pic_inta_sequencer
    import pic_pkg::*;
#(
    parameter bit                SYNC_INTA      = 1'b1,
    parameter logic [LVL_W-1:0]  SPURIOUS_LEVEL = 3'd7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       interrupt_vector,
    input  logic             inta_n,
    input  logic             init_clear,
    input  logic [4:0]       vector_base,
    input  logic             auto_eoi,
    input  logic             ocw2_valid,
    input  logic [2:0]       ocw2_cmd,
    input  logic [LVL_W-1:0] ocw2_level,
    output logic             int_out,
    output logic [7:0]       isr,
    output logic [7:0]       irr_clear,
    output logic [LVL_W-1:0] priority_rotate,
    output logic [7:0]       data_out,
    output logic             data_out_en
);
    state_t           state_q, state_d;
    logic             int_q, int_d;
    logic [7:0]       isr_q, isr_d;
    logic [7:0]       irr_q, irr_d;
    logic [LVL_W-1:0] rot_q, rot_d;
    logic [7:0]       dout_q, dout_d;
    logic             den_q, den_d;
    logic             raeoi_q, raeoi_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic             spur_q, spur_d;
    logic             fall, rise;
    logic [3:0]       hit;
    logic [LVL_W-1:0] req_lvl;

    inta_edge_detect #(.SYNC_INTA(SYNC_INTA)) u_edge (
        .clk      (clk),
        .reset    (reset),
        .inta_n_i (inta_n),
        .fall_o   (fall),
        .rise_o   (rise)
    );

    // {found, level} of the first set ISR bit, scanning upward from the rotation point.
    function automatic logic [3:0] isr_highest(input logic [7:0] v, input logic [LVL_W-1:0] r);
        isr_highest = '0;
        for (int i = 7; i >= 0; i--)
            if (v[r + LVL_W'(i)]) isr_highest = {1'b1, r + LVL_W'(i)};
    endfunction

    assign hit     = isr_highest(isr_q, rot_q);
    assign req_lvl = onehot_to_level(interrupt_vector);

    always_comb begin
        state_d = state_q;
        int_d   = int_q;
        isr_d   = isr_q;
        irr_d   = '0;
        rot_d   = rot_q;
        dout_d  = dout_q;
        den_d   = den_q;
        raeoi_d = raeoi_q;
        lvl_d   = lvl_q;
        spur_d  = spur_q;
        // EOI clears are applied first so a same-cycle ACK1 set overrides them.
        if (ocw2_valid) begin
            case (ocw2_cmd)
                OCW2_NS_EOI, OCW2_ROT_NS: if (hit[3]) begin
                    isr_d[hit[2:0]] = 1'b0;
                    if (ocw2_cmd == OCW2_ROT_NS) rot_d = hit[2:0] + 3'd1;
                end
                OCW2_S_EOI, OCW2_ROT_S: begin
                    isr_d[ocw2_level] = 1'b0;
                    if (ocw2_cmd == OCW2_ROT_S) rot_d = ocw2_level + 3'd1;
                end
                OCW2_SET_PRI:  rot_d   = ocw2_level + 3'd1;
                OCW2_AEOI_SET: raeoi_d = 1'b1;
                OCW2_AEOI_CLR: raeoi_d = 1'b0;
                default: ;
            endcase
        end
        case (state_q)
            IDLE: begin
                int_d = int_q | (|interrupt_vector);
                if (fall && int_q) begin
                    state_d = ACK1;
                    int_d   = 1'b0;
                    spur_d  = ~|interrupt_vector;
                    lvl_d   = spur_d ? SPURIOUS_LEVEL : req_lvl;
                    if (!spur_d) begin
                        isr_d[req_lvl] = 1'b1;
                        irr_d[req_lvl] = 1'b1;
                    end
                end
            end
            ACK1: state_d = rise ? WAIT2 : ACK1;
            WAIT2: if (fall) begin
                state_d = ACK2;
                dout_d  = {vector_base, lvl_q};
                den_d   = 1'b1;
            end
            ACK2: if (rise) begin
                state_d = IDLE;
                den_d   = 1'b0;
                if (auto_eoi && !spur_q) begin
                    isr_d[lvl_q] = 1'b0;
                    if (raeoi_q) rot_d = lvl_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (init_clear) begin
            state_d = IDLE;
            int_d   = 1'b0;
            isr_d   = '0;
            irr_d   = '0;
            rot_d   = '0;
            dout_d  = '0;
            den_d   = 1'b0;
            raeoi_d = 1'b0;
            lvl_d   = '0;
            spur_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            int_q   <= 1'b0;
            isr_q   <= '0;
            irr_q   <= '0;
            rot_q   <= '0;
            dout_q  <= '0;
            den_q   <= 1'b0;
            raeoi_q <= 1'b0;
            lvl_q   <= '0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
            isr_q   <= isr_d;
            irr_q   <= irr_d;
            rot_q   <= rot_d;
            dout_q  <= dout_d;
            den_q   <= den_d;
            raeoi_q <= raeoi_d;
            lvl_q   <= lvl_d;
            spur_q  <= spur_d;
        end
    end

    assign int_out         = int_q;
    assign isr             = isr_q;
    assign irr_clear       = irr_q;
    assign priority_rotate = rot_q;
    assign data_out        = dout_q;
    assign data_out_en     = den_q;
endmodule
